atm_txn_initiator: RTL and testbench
====================================

ATM_TXN_INITIATOR -- requirements
Module: atm_txn_initiator

Interface
REQ-001 SHALL have ports: clk input 1, system clock; rst input 1, synchronous active-high reset; one clock, reset is synchronous and active-high.
REQ-002 SHALL have params: LOGIN_HOLD, 3, cycles account/PIN held; OP_HOLD, 5, cycles operation held; EXIT_HOLD, 4, cycles exit op held.
REQ-003 SHALL have request ports: req_valid in 1; req_ready out 1; req_acct in 12; req_pin in 12; req_dst in 12; req_op in 3; req_amount in 12.
REQ-004 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_balance out 12; rsp_dst_balance out 12; rsp_err out 1.
REQ-005 SHALL have ATM-side ports: Account_Number, PIN, Destination_Account, WithDraw_Amount, Transfer_Amount, Deposit_Amount out 12 each; Operation out 3; FinalBalance, Final_DstBalance in 12 each.

Function
REQ-006 SHALL implement states IDLE, LOGIN, OPER, REPORT, EXIT, RESP.
REQ-007 SHALL assert req_ready only in IDLE; accept on req_valid&&req_ready, registering all req_* fields.
REQ-008 SHALL on a valid accept go to LOGIN; invalid req_op (5, 6, 7) SHALL instead go directly to RESP with rsp_err=1, balances 0, ATM outputs untouched (rsp_valid the cycle after accept).
REQ-009 SHALL in LOGIN drive Account_Number, PIN, Destination_Account from registered request, Operation=0, all amounts 0, for LOGIN_HOLD cycles.
REQ-010 SHALL in OPER keep LOGIN values, drive Operation=req_op and route req_amount to the one matching amount port only (0 deposit, 1 withdraw, 2 transfer), others 0; op 3 (inquiry) drives all amounts 0; hold OP_HOLD cycles.
REQ-011 SHALL in REPORT drive Operation=6, amounts 0, for 2 cycles, capturing FinalBalance/Final_DstBalance on the last REPORT cycle edge.
REQ-012 SHALL in EXIT drive Operation=4 for EXIT_HOLD cycles, then drive Account_Number/PIN/Destination_Account to 0 and enter RESP.
REQ-013 SHALL assert rsp_valid exactly LOGIN_HOLD+OP_HOLD+2+EXIT_HOLD+1 cycles (15 default) after the accept edge; rsp_* held stable until rsp_valid&&rsp_ready, then IDLE next cycle.
REQ-014 SHALL in IDLE and RESP drive all ATM-side outputs to 0.
REQ-015 SHALL use an internal hold counter wide enough for max(LOGIN_HOLD,OP_HOLD,EXIT_HOLD); no wrap-around permitted; hold values of 0 treated as 1.
REQ-016 SHALL ignore req_valid in every non-IDLE state (no queueing).

Reset
REQ-017 SHALL on rst (sampled at clk edge) force IDLE, all outputs 0, req_ready=1 next cycle, including mid-LOGIN/OPER/REPORT/EXIT/RESP; pending response discarded.

Configuration
REQ-018 SHALL with ATM_INIT_ZERO_AMT_CHECK_EN defined reject req_op 0/1/2 with req_amount==0 as in REQ-008 (rsp_err=1, no ATM activity); without it such requests run the full sequence.

Structure
REQ-019 SHALL place in shared package atm_pkg: 12-bit data width, 3-bit op width, op encodings (DEPOSIT=0, WITHDRAW=1, TRANSFER=2, INQUIRY=3, EXIT=4, REPORT=6), state enum, hold defaults.
REQ-020 SHALL use one sub-module atm_hold_counter (load, decrement, done flag).

Verification
REQ-021 Deposit acct 0xfff pin 0xfff amt 0x11f, ATM model returns FinalBalance 0x51f -> Deposit_Amount=0x11f during OPER only; rsp_valid 15 cycles after accept, rsp_balance=0x51f, rsp_err=0.
REQ-022 Transfer acct 0xfff dst 0x456 amt 0x012, model returns 0x3ed/0x112 -> Transfer_Amount=0x012, other amounts 0; rsp_balance=0x3ed, rsp_dst_balance=0x112.
REQ-023 req_op=5 -> rsp_err=1 one cycle after accept, Operation stays 0 throughout.
REQ-024 Withdraw amt 0 -> with ATM_INIT_ZERO_AMT_CHECK_EN rsp_err=1 next cycle; without, full 15-cycle sequence, rsp_err=0.
REQ-025 rsp_ready low 3 cycles after rsp_valid -> rsp_* stable, req_ready low; IDLE and req_ready=1 cycle after handshake.
REQ-026 rst pulsed in 2nd OPER cycle -> next cycle all ATM outputs 0, rsp_valid 0, req_ready 1; new request then completes normally.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared widths, op encodings, state enum and hold defaults for the ATM
// transaction initiator.
package atm_pkg;

   localparam int DW = 12;
   localparam int OW = 3;

   localparam logic [OW-1:0] OP_DEPOSIT  = 3'd0;
   localparam logic [OW-1:0] OP_WITHDRAW = 3'd1;
   localparam logic [OW-1:0] OP_TRANSFER = 3'd2;
   localparam logic [OW-1:0] OP_INQUIRY  = 3'd3;
   localparam logic [OW-1:0] OP_EXIT     = 3'd4;
   localparam logic [OW-1:0] OP_REPORT   = 3'd6;

   localparam int LOGIN_HOLD_DEF = 3;
   localparam int OP_HOLD_DEF    = 5;
   localparam int EXIT_HOLD_DEF  = 4;
   localparam int REPORT_HOLD    = 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOGIN  = 3'd1,
      S_OPER   = 3'd2,
      S_REPORT = 3'd3,
      S_EXIT   = 3'd4,
      S_RESP   = 3'd5
   } state_e;

   // counter reload value; a hold of 0 still lasts one cycle
   function automatic int hold_ld(input int h);
      return (h > 1) ? h - 1 : 0;
   endfunction

   function automatic int max_hold(input int a, input int b,
                                   input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/atm_txn_initiator_if.sv
// Request/response handshake bundle between a host and the ATM
// transaction initiator.
interface atm_txn_initiator_if;
   import atm_pkg::*;

   logic          req_valid;
   logic          req_ready;
   logic [DW-1:0] req_acct;
   logic [DW-1:0] req_pin;
   logic [DW-1:0] req_dst;
   logic [OW-1:0] req_op;
   logic [DW-1:0] req_amount;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_balance;
   logic [DW-1:0] rsp_dst_balance;
   logic          rsp_err;

   modport master (
      output req_valid, req_acct, req_pin, req_dst, req_op, req_amount,
      input  req_ready,
      input  rsp_valid, rsp_balance, rsp_dst_balance, rsp_err,
      output rsp_ready
   );

   modport slave (
      input  req_valid, req_acct, req_pin, req_dst, req_op, req_amount,
      output req_ready,
      output rsp_valid, rsp_balance, rsp_dst_balance, rsp_err,
      input  rsp_ready
   );

endinterface

// File: rtl/atm_hold_counter.sv
// Loadable down-counter that saturates at zero; done marks the last
// cycle of a hold window.
module atm_hold_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/atm_txn_initiator.sv
// Sequences one ATM transaction (login, operation, report, exit) per request.
// Option: ATM_INIT_ZERO_AMT_CHECK_EN rejects zero-amount deposit/withdraw/transfer.
module atm_txn_initiator
   import atm_pkg::*;
#(
   parameter int LOGIN_HOLD = LOGIN_HOLD_DEF,
   parameter int OP_HOLD    = OP_HOLD_DEF,
   parameter int EXIT_HOLD  = EXIT_HOLD_DEF
) (
   input  logic          clk,
   input  logic          rst,
   atm_txn_initiator_if.slave bus,
   output logic [DW-1:0] Account_Number,
   output logic [DW-1:0] PIN,
   output logic [DW-1:0] Destination_Account,
   output logic [DW-1:0] WithDraw_Amount,
   output logic [DW-1:0] Transfer_Amount,
   output logic [DW-1:0] Deposit_Amount,
   output logic [OW-1:0] Operation,
   input  logic [DW-1:0] FinalBalance,
   input  logic [DW-1:0] Final_DstBalance
);

   localparam int MAXH = max_hold(LOGIN_HOLD, OP_HOLD, EXIT_HOLD, REPORT_HOLD);
   localparam int CW   = $clog2(MAXH + 1);

   state_e        state;
   logic [DW-1:0] r_acct, r_pin, r_dst, r_amt;
   logic [OW-1:0] r_op;
   logic          accept, reject, active;
   logic          ld, done;
   logic [CW-1:0] ld_val;

   assign bus.req_ready = (state == S_IDLE);
   assign accept = bus.req_valid && bus.req_ready;

`ifdef ATM_INIT_ZERO_AMT_CHECK_EN
   assign reject = (bus.req_op > OP_EXIT) ||
                   (bus.req_op <= OP_TRANSFER && bus.req_amount == '0);
`else
   assign reject = (bus.req_op > OP_EXIT);
`endif

   always_comb begin
      ld     = 1'b0;
      ld_val = '0;
      unique case (state)
         S_IDLE: if (accept && !reject) begin
            ld     = 1'b1;
            ld_val = CW'(hold_ld(LOGIN_HOLD));
         end
         S_LOGIN: if (done) begin
            ld     = 1'b1;
            ld_val = CW'(hold_ld(OP_HOLD));
         end
         S_OPER: if (done) begin
            ld     = 1'b1;
            ld_val = CW'(hold_ld(REPORT_HOLD));
         end
         S_REPORT: if (done) begin
            ld     = 1'b1;
            ld_val = CW'(hold_ld(EXIT_HOLD));
         end
         default: ;
      endcase
   end

   atm_hold_counter #(.W(CW)) u_hold (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .load_val (ld_val),
      .dec      (1'b1),
      .done     (done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= S_IDLE;
         r_acct              <= '0;
         r_pin               <= '0;
         r_dst               <= '0;
         r_amt               <= '0;
         r_op                <= '0;
         bus.rsp_valid       <= 1'b0;
         bus.rsp_err         <= 1'b0;
         bus.rsp_balance     <= '0;
         bus.rsp_dst_balance <= '0;
      end else begin
         unique case (state)
            S_IDLE: if (accept) begin
               r_acct              <= bus.req_acct;
               r_pin               <= bus.req_pin;
               r_dst               <= bus.req_dst;
               r_amt               <= bus.req_amount;
               r_op                <= bus.req_op;
               bus.rsp_err         <= reject;
               bus.rsp_balance     <= '0;
               bus.rsp_dst_balance <= '0;
               state <= reject ? S_RESP : S_LOGIN;
            end
            S_LOGIN: if (done) state <= S_OPER;
            S_OPER:  if (done) state <= S_REPORT;
            S_REPORT: if (done) begin
               bus.rsp_balance     <= FinalBalance;
               bus.rsp_dst_balance <= Final_DstBalance;
               state <= S_EXIT;
            end
            S_EXIT: if (done) state <= S_RESP;
            S_RESP: begin
               // rsp_valid rises one cycle after entering RESP
               if (!bus.rsp_valid) begin
                  bus.rsp_valid <= 1'b1;
               end else if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign active = state inside {S_LOGIN, S_OPER, S_REPORT, S_EXIT};

   always_comb begin
      Account_Number      = '0;
      PIN                 = '0;
      Destination_Account = '0;
      WithDraw_Amount     = '0;
      Transfer_Amount     = '0;
      Deposit_Amount      = '0;
      Operation           = '0;
      if (active) begin
         Account_Number      = r_acct;
         PIN                 = r_pin;
         Destination_Account = r_dst;
      end
      unique case (state)
         S_OPER: begin
            Operation = r_op;
            case (r_op)
               OP_DEPOSIT:  Deposit_Amount  = r_amt;
               OP_WITHDRAW: WithDraw_Amount = r_amt;
               OP_TRANSFER: Transfer_Amount = r_amt;
               default: ;
            endcase
         end
         S_REPORT: Operation = OP_REPORT;
         S_EXIT:   Operation = OP_EXIT;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_atm_txn_initiator.sv
// Scoreboard bench for atm_txn_initiator: per-cycle ATM-side model,
// response latency/content, backpressure and mid-transaction reset.
module tb_atm_txn_initiator;
   import atm_pkg::*;

   localparam int LH   = 3;
   localparam int OH   = 5;
   localparam int EH   = 4;
   localparam int T_OP = LH;
   localparam int T_RP = LH + OH;
   localparam int T_EX = LH + OH + 2;
   localparam int T_RS = LH + OH + 2 + EH;
   localparam int LAT  = T_RS + 1;

`ifdef ATM_INIT_ZERO_AMT_CHECK_EN
   localparam bit ZREJ = 1'b1;
`else
   localparam bit ZREJ = 1'b0;
`endif

   typedef struct {
      logic        err;
      logic [11:0] bal;
      logic [11:0] dbal;
      int          lat;
   } exp_t;

   exp_t sbq[$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [11:0] fin_bal = '0;
   logic [11:0] fin_dst = '0;
   logic [11:0] acct_o, pin_o, dst_o, wd_o, tr_o, dep_o;
   logic [2:0]  op_o;

   atm_txn_initiator_if bus();

   atm_txn_initiator #(
      .LOGIN_HOLD (LH),
      .OP_HOLD    (OH),
      .EXIT_HOLD  (EH)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .bus                 (bus),
      .Account_Number      (acct_o),
      .PIN                 (pin_o),
      .Destination_Account (dst_o),
      .WithDraw_Amount     (wd_o),
      .Transfer_Amount     (tr_o),
      .Deposit_Amount      (dep_o),
      .Operation           (op_o),
      .FinalBalance        (fin_bal),
      .Final_DstBalance    (fin_dst)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [79:0] got,
                      input logic [79:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic atm_chk(input string tag,
                          input logic [11:0] a, p, d,
                          input logic [2:0] o,
                          input logic [11:0] dp, wd, tr);
      chk(tag, {acct_o, pin_o, dst_o, op_o, dep_o, wd_o, tr_o},
               {a, p, d, o, dp, wd, tr});
   endtask

   task automatic drive_req(input logic [11:0] acct, pin, dst,
                            input logic [2:0] op, input logic [11:0] amt);
      bus.req_valid  = 1'b1;
      bus.req_acct   = acct;
      bus.req_pin    = pin;
      bus.req_dst    = dst;
      bus.req_op     = op;
      bus.req_amount = amt;
   endtask

   task automatic txn(input logic [11:0] acct, pin, dst,
                      input logic [2:0] op, input logic [11:0] amt,
                      input logic [11:0] fb, fdb,
                      input bit rej, input int stall);
      exp_t e, g;
      int acc, d;
      bit seen;
      logic [11:0] ea, ep, ed, edp, ewd, etr;
      logic [2:0] eo;
      fin_bal = fb;
      fin_dst = fdb;
      bus.rsp_ready = (stall == 0);
      @(negedge clk);
      chk("req_ready_idle", bus.req_ready, 1'b1);
      drive_req(acct, pin, dst, op, amt);
      acc    = cyc + 1;
      e.err  = rej;
      e.bal  = rej ? 12'h0 : fb;
      e.dbal = rej ? 12'h0 : fdb;
      e.lat  = rej ? 1 : LAT;
      sbq.push_back(e);
      seen = 1'b0;
      d = 0;
      for (int n = 0; n < LAT + 10 && !seen; n++) begin
         @(negedge clk);
         d = cyc - acc;
         // garbage requests while busy must be ignored
         bus.req_valid  = !rej && d < T_EX;
         bus.req_acct   = 12'($urandom);
         bus.req_pin    = 12'($urandom);
         bus.req_dst    = 12'($urandom);
         bus.req_op     = 3'd5;
         bus.req_amount = 12'($urandom);
         if (bus.rsp_valid) begin
            seen = 1'b1;
         end else begin
            {ea, ep, ed, edp, ewd, etr, eo} = '0;
            if (!rej && d < T_RS) begin
               ea = acct;
               ep = pin;
               ed = dst;
               if (d < T_OP)      eo = 3'd0;
               else if (d < T_RP) eo = op;
               else if (d < T_EX) eo = 3'd6;
               else               eo = 3'd4;
               if (d >= T_OP && d < T_RP) begin
                  if (op == 3'd0) edp = amt;
                  if (op == 3'd1) ewd = amt;
                  if (op == 3'd2) etr = amt;
               end
            end
            atm_chk("atm_out", ea, ep, ed, eo, edp, ewd, etr);
            chk("req_ready_busy", bus.req_ready, 1'b0);
         end
      end
      bus.req_valid = 1'b0;
      chk("rsp_seen", seen, 1'b1);
      if (seen) begin
         g = sbq.pop_front();
         chk("rsp_lat", d, g.lat);
         chk("rsp_err", bus.rsp_err, g.err);
         chk("rsp_bal", bus.rsp_balance, g.bal);
         chk("rsp_dbal", bus.rsp_dst_balance, g.dbal);
         atm_chk("atm_resp", '0, '0, '0, '0, '0, '0, '0);
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", bus.rsp_valid, 1'b1);
            chk("stall_rsp", {bus.rsp_err, bus.rsp_balance, bus.rsp_dst_balance},
                             {g.err, g.bal, g.dbal});
            chk("stall_ready", bus.req_ready, 1'b0);
         end
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         chk("rsp_drop", bus.rsp_valid, 1'b0);
         chk("req_ready_back", bus.req_ready, 1'b1);
      end else begin
         sbq.delete();
      end
   endtask

   initial begin
      exp_t e;
      int acc;
      bus.req_valid  = 1'b0;
      bus.req_acct   = '0;
      bus.req_pin    = '0;
      bus.req_dst    = '0;
      bus.req_op     = '0;
      bus.req_amount = '0;
      bus.rsp_ready  = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_balance,
                      bus.rsp_dst_balance}, '0);
      atm_chk("rst_atm", '0, '0, '0, '0, '0, '0, '0);
      rst = 1'b0;

      txn(12'hfff, 12'hfff, 12'h000, 3'd0, 12'h11f, 12'h51f, 12'h000, 1'b0, 0);
      txn(12'hfff, 12'h321, 12'h456, 3'd2, 12'h012, 12'h3ed, 12'h112, 1'b0, 0);
      txn(12'h0a1, 12'h0b2, 12'h0c3, 3'd5, 12'h044, 12'h777, 12'h666, 1'b1, 0);
      txn(12'h123, 12'h456, 12'h000, 3'd1, 12'h000, 12'h0aa, 12'h0bb, ZREJ, 0);
      txn(12'h234, 12'h567, 12'h089, 3'd1, 12'h050, 12'h100, 12'h000, 1'b0, 0);
      txn(12'h345, 12'h678, 12'h000, 3'd3, 12'h099, 12'h200, 12'h001, 1'b0, 3);
      txn(12'h001, 12'h002, 12'h003, 3'd7, 12'h010, 12'h300, 12'h300, 1'b1, 2);
      txn(12'h00e, 12'h00f, 12'h010, 3'd4, 12'h020, 12'h040, 12'h050, 1'b0, 0);

      // reset in the second OPER cycle discards the transaction
      fin_bal = 12'h5a5;
      fin_dst = 12'h0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      drive_req(12'h777, 12'h888, 12'h999, 3'd0, 12'h0ff);
      acc    = cyc + 1;
      e.err  = 1'b0;
      e.bal  = 12'h5a5;
      e.dbal = 12'h0;
      e.lat  = LAT;
      sbq.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int n = 0; n < 20 && (cyc - acc) < T_OP + 1; n++) @(negedge clk);
      chk("pre_rst_dep", dep_o, 12'h0ff);
      rst = 1'b1;
      @(negedge clk);
      atm_chk("mid_rst_atm", '0, '0, '0, '0, '0, '0, '0);
      chk("mid_rst_valid", bus.rsp_valid, 1'b0);
      chk("mid_rst_ready", bus.req_ready, 1'b1);
      rst = 1'b0;
      void'(sbq.pop_back());

      txn(12'h777, 12'h888, 12'h999, 3'd0, 12'h0ff, 12'h5a5, 12'h000, 1'b0, 0);

      chk("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
